sprite_blitter: RTL and testbench
=================================

SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, visible width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 480, visible height in pixels.
REQ-003 SHALL have parameter TRANSPARENT_KEY, default 12'h000, colour skipped when transparency is compiled in.
REQ-004 SHALL have clk, input, 1, sole clock; all logic on rising edge; one clock, reset synchronous and active-high.
REQ-005 SHALL have rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have req_valid, input, 1, draw request present.
REQ-007 SHALL have req_ready, output, 1, blitter idle and able to accept.
REQ-008 SHALL have req_id, input, 6, object id 0-35 (others: 1x1 default).
REQ-009 SHALL have req_x and req_y, input, 11 each, top-left screen coordinate.
REQ-010 SHALL have obj_id, output, 6, id driven to the object geometry table.
REQ-011 SHALL have obj_h, obj_w, input, 11 each, and obj_addr, input, 19, combinational geometry returned for obj_id.
REQ-012 SHALL have rom_addr, output, 19, and rom_data, input, 12, sprite ROM with 1-cycle read latency.
REQ-013 SHALL have fb_we, output, 1; fb_x, fb_y, output, 11 each; fb_data, output, 12; framebuffer write port.
REQ-014 SHALL have busy, output, 1, and done, output, 1, single-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, SETUP, RUN, DRAIN; req_ready = (state==IDLE), busy = !req_ready.
REQ-016 SHALL accept when req_valid && req_ready, latching req_id/x/y; req_valid ignored in all other states.
REQ-017 SHALL hold obj_id at the latched id from accept until the next accept (0 after reset).
REQ-018 SETUP (1 cycle) SHALL capture obj_h, obj_w, obj_addr and clear row/column counters.
REQ-019 RUN SHALL issue one ROM read per cycle, rom_addr = obj_addr + row*w + col, row-major, advanced by increment (no multiplier), col wraps at w-1 and row increments.
REQ-020 RUN SHALL last exactly h*w cycles, then go to DRAIN (1 cycle) and then IDLE.
REQ-021 Pixel issued at cycle N SHALL produce fb_we at N+1 with fb_x = x+col, fb_y = y+row, fb_data = rom_data.
REQ-022 Coordinate sums SHALL be computed 12 bits wide; fb_we suppressed when sum >= SCREEN_W or >= SCREEN_H (clipping, no wrap).
REQ-023 done SHALL pulse in DRAIN, coincident with the final pixel's write slot; new accept possible the following cycle.
REQ-024 Latency for a h*w sprite accepted at T: first write slot T+3, last T+h*w+2, done T+h*w+2, req_ready T+h*w+3.
REQ-025 Unknown id (1x1 geometry) SHALL blit exactly one pixel from ROM address 0.
REQ-026 fb_x, fb_y, fb_data are don't-care when fb_we=0; rom_addr holds its last value outside RUN.

Reset
REQ-027 rst SHALL force IDLE; req_ready=1, busy=0, done=0, fb_we=0, obj_id=0, rom_addr=0, counters 0.
REQ-028 rst during SETUP/RUN/DRAIN SHALL abort: no fb_we from the cycle after rst asserts, no done pulse.

Configuration
REQ-029 Macro BLIT_TRANSPARENT_EN defined: fb_we additionally suppressed when rom_data == TRANSPARENT_KEY.
REQ-030 Macro BLIT_TRANSPARENT_EN undefined: every in-bounds pixel written regardless of colour; timing identical.

Verification
REQ-031 id=0 at (100,50), ROM ramp data, accept at T -> 1600 writes T+3..T+1602, first (100,50) addr 0, last (139,89) addr 1599, done at T+1602.
REQ-032 id=9 at (600,450) -> only 40x30 in-bounds writes (x 600-639, y 450-479); total cycles unchanged.
REQ-033 id=63 at (10,10) -> single write (10,10) from rom_addr 0; done at T+3.
REQ-034 BLIT_TRANSPARENT_EN, id=4, every other ROM word 12'h000 -> 800 writes; without macro -> 1600.
REQ-035 rst asserted mid-RUN of id=25 -> fb_we=0 from next cycle, no done, req_ready=1, next request id=1 completes normally.
REQ-036 Back-to-back requests held valid -> second accepted the cycle after first done; obj_id changes only at accept.

Source files
------------

// File: rtl/sprite_blitter_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_blitter_if
// Brief    : Draw-request handshake between a requester and the sprite blitter.
// Revision : 1.0
// ============================================================================
interface sprite_blitter_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_id;
  logic [10:0] req_x;
  logic [10:0] req_y;

  modport master (output req_valid, req_id, req_x, req_y, input req_ready);
  modport slave  (input req_valid, req_id, req_x, req_y, output req_ready);
endinterface
`default_nettype wire

// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_blitter
// Brief    : Copies a sprite from ROM to the framebuffer with screen clipping.
//            Define BLIT_TRANSPARENT_EN to skip pixels equal to TRANSPARENT_KEY.
// Revision : 1.0
// ============================================================================
module sprite_blitter #(
  parameter int          SCREEN_W        = 640,
  parameter int          SCREEN_H        = 480,
  parameter logic [11:0] TRANSPARENT_KEY = 12'h000
) (
  input  logic             clk,
  input  logic             rst,
  sprite_blitter_if.slave  req,
  output logic [5:0]       obj_id,
  input  logic [10:0]      obj_h,
  input  logic [10:0]      obj_w,
  input  logic [18:0]      obj_addr,
  output logic [18:0]      rom_addr,
  input  logic [11:0]      rom_data,
  output logic             fb_we,
  output logic [10:0]      fb_x,
  output logic [10:0]      fb_y,
  output logic [11:0]      fb_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [11:0] c_scr_w = 12'(SCREEN_W);
  localparam logic [11:0] c_scr_h = 12'(SCREEN_H);

`ifdef BLIT_TRANSPARENT_EN
  localparam logic c_key_en = 1'b1;
`else
  localparam logic c_key_en = 1'b0;
`endif

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_id;
  logic [10:0] r_x, r_y, r_h, r_w, r_row, r_col;
  logic [18:0] r_addr;
  logic        r_wr_pend;
  logic [10:0] r_px, r_py;
  logic        w_accept, w_col_wrap, w_last, w_ready, w_done;
  logic [11:0] w_sx, w_sy;

  assign w_accept   = req.req_valid && w_ready;
  assign w_col_wrap = (r_col == r_w - 11'd1);
  assign w_last     = w_col_wrap && (r_row == r_h - 11'd1);
  // 12-bit sums so an off-screen coordinate is clipped instead of wrapping
  assign w_sx       = {1'b0, r_x} + {1'b0, r_col};
  assign w_sy       = {1'b0, r_y} + {1'b0, r_row};

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (req.req_valid) w_state_nxt = S_SETUP;
      end
      S_SETUP: w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_id      <= 6'd0;
      r_x       <= 11'd0;
      r_y       <= 11'd0;
      r_h       <= 11'd0;
      r_w       <= 11'd0;
      r_row     <= 11'd0;
      r_col     <= 11'd0;
      r_addr    <= 19'd0;
      r_wr_pend <= 1'b0;
      r_px      <= 11'd0;
      r_py      <= 11'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_pend <= 1'b0;
      if (w_accept) begin
        r_id <= req.req_id;
        r_x  <= req.req_x;
        r_y  <= req.req_y;
      end
      unique case (r_state)
        S_SETUP: begin
          r_h    <= obj_h;
          r_w    <= obj_w;
          r_addr <= obj_addr;
          r_row  <= 11'd0;
          r_col  <= 11'd0;
        end
        S_RUN: begin
          r_wr_pend <= (w_sx < c_scr_w) && (w_sy < c_scr_h);
          r_px      <= w_sx[10:0];
          r_py      <= w_sy[10:0];
          // Address stays on the last pixel once the sprite is exhausted
          if (!w_last) begin
            r_addr <= r_addr + 19'd1;
            if (w_col_wrap) begin
              r_col <= 11'd0;
              r_row <= r_row + 11'd1;
            end else begin
              r_col <= r_col + 11'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign req.req_ready = w_ready;
  assign busy          = !w_ready;
  assign done          = w_done;
  assign obj_id        = r_id;
  assign rom_addr      = r_addr;
  assign fb_we         = r_wr_pend && !(c_key_en && (rom_data == TRANSPARENT_KEY));
  assign fb_x          = r_px;
  assign fb_y          = r_py;
  assign fb_data       = rom_data;

endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_blitter
// Brief    : Directed vector bench for sprite_blitter with geometry/ROM models.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sprite_blitter;

`ifdef BLIT_TRANSPARENT_EN
  localparam bit tr = 1'b1;
`else
  localparam bit tr = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  obj_id;
  logic [10:0] obj_h, obj_w;
  logic [18:0] obj_addr, rom_addr;
  logic [11:0] rom_data, fb_data;
  logic        fb_we, busy, done;
  logic [10:0] fb_x, fb_y;

  always #5 clk = ~clk;

  sprite_blitter_if bus();

  sprite_blitter #(
    .SCREEN_W       (640),
    .SCREEN_H       (480),
    .TRANSPARENT_KEY(12'h000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (bus),
    .obj_id   (obj_id),
    .obj_h    (obj_h),
    .obj_w    (obj_w),
    .obj_addr (obj_addr),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .fb_we    (fb_we),
    .fb_x     (fb_x),
    .fb_y     (fb_y),
    .fb_data  (fb_data),
    .busy     (busy),
    .done     (done)
  );

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] w;
    logic [18:0] base;
  } geo_t;

  function automatic geo_t geo(input logic [5:0] id);
    geo_t g;
    case (id)
      6'd0:    g = '{h: 11'd40, w: 11'd40, base: 19'd0};
      6'd1:    g = '{h: 11'd2,  w: 11'd3,  base: 19'd100};
      6'd4:    g = '{h: 11'd40, w: 11'd40, base: 19'd2000};
      6'd9:    g = '{h: 11'd64, w: 11'd64, base: 19'd8192};
      6'd25:   g = '{h: 11'd10, w: 11'd10, base: 19'd300};
      default: begin
        if (id < 6'd36) g = '{h: 11'd2, w: 11'd2, base: 19'(id) * 19'd16};
        else            g = '{h: 11'd1, w: 11'd1, base: 19'd0};
      end
    endcase
    return g;
  endfunction

  // Odd addresses hold the transparent colour, even ones a non-zero ramp
  function automatic logic [11:0] rom_f(input logic [18:0] a);
    return a[0] ? 12'h000 : (a[11:0] + 12'd1);
  endfunction

  geo_t g_cur;
  always_comb begin
    g_cur    = geo(obj_id);
    obj_h    = g_cur.h;
    obj_w    = g_cur.w;
    obj_addr = g_cur.base;
  end

  always @(posedge clk) rom_data <= rom_f(rom_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_wr, first_cyc, last_cyc, n_done, done_cyc, data_err;
  int cur_x, cur_y, cur_w, cur_base;
  logic [10:0] fx, fy, lx, ly;

  always @(negedge clk) begin
    int exp_a;
    if (fb_we) begin
      if (n_wr == 0) begin
        first_cyc = cyc;
        fx = fb_x;
        fy = fb_y;
      end
      last_cyc = cyc;
      lx = fb_x;
      ly = fb_y;
      n_wr++;
      exp_a = cur_base + (int'(fb_y) - cur_y) * cur_w + (int'(fb_x) - cur_x);
      if (fb_data !== rom_f(19'(exp_a))) data_err++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clear_stats();
    n_wr = 0; n_done = 0; data_err = 0;
    first_cyc = -1; last_cyc = -1; done_cyc = -1;
  endtask

  typedef struct {
    logic [5:0] id;
    int x, y, n, f_off, fx, fy, l_off, lx, ly, d_off;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input int i, input vec_t v);
    geo_t g;
    int   t, k;
    g = geo(v.id);
    @(negedge clk);
    cur_x = v.x; cur_y = v.y; cur_w = int'(g.w); cur_base = int'(g.base);
    clear_stats();
    bus.req_valid = 1'b1;
    bus.req_id    = v.id;
    bus.req_x     = 11'(v.x);
    bus.req_y     = 11'(v.y);
    k = 0;
    while (!bus.req_ready && k < 100) begin @(negedge clk); k++; end
    chk($sformatf("v%0d_accept", i), longint'(bus.req_ready), 1);
    t = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    k = 0;
    while (!done && k < 6000) begin @(negedge clk); k++; end
    @(negedge clk);
    chk($sformatf("v%0d_ready_off", i), (bus.req_ready == 1'b1) ? cyc - t : -1, v.d_off + 1);
    chk($sformatf("v%0d_writes", i), n_wr, v.n);
    chk($sformatf("v%0d_first_off", i), first_cyc - t, v.f_off);
    chk($sformatf("v%0d_first_xy", i), {fx, fy}, {11'(v.fx), 11'(v.fy)});
    chk($sformatf("v%0d_last_off", i), last_cyc - t, v.l_off);
    chk($sformatf("v%0d_last_xy", i), {lx, ly}, {11'(v.lx), 11'(v.ly)});
    chk($sformatf("v%0d_data_err", i), data_err, 0);
    chk($sformatf("v%0d_done_off", i), done_cyc - t, v.d_off);
    chk($sformatf("v%0d_done_cnt", i), n_done, 1);
  endtask

  logic       rec_ready[15];
  logic       rec_done[15];
  logic [5:0] rec_obj[15];

  initial begin
    int t, k;
    vecs[0] = '{6'd1,  5,   7,   tr ? 3 : 6,       3, 5,   7,   tr ? 7 : 8,       tr ? 6 : 7,     8,   8};
    vecs[1] = '{6'd0,  100, 50,  tr ? 800 : 1600,  3, 100, 50,  tr ? 1601 : 1602, tr ? 138 : 139, 89,  1602};
    vecs[2] = '{6'd9,  600, 450, tr ? 600 : 1200,  3, 600, 450, tr ? 1897 : 1898, tr ? 638 : 639, 479, 4098};
    vecs[3] = '{6'd63, 10,  10,  1,                3, 10,  10,  3,                10,             10,  3};
    vecs[4] = '{6'd4,  0,   0,   tr ? 800 : 1600,  3, 0,   0,   tr ? 1601 : 1602, tr ? 38 : 39,   39,  1602};

    bus.req_valid = 1'b0;
    bus.req_id    = 6'd0;
    bus.req_x     = 11'd0;
    bus.req_y     = 11'd0;
    clear_stats();

    repeat (3) @(negedge clk);
    chk("rst_ready",    longint'(bus.req_ready), 1);
    chk("rst_busy",     longint'(busy), 0);
    chk("rst_done",     longint'(done), 0);
    chk("rst_fb_we",    longint'(fb_we), 0);
    chk("rst_obj_id",   longint'(obj_id), 0);
    chk("rst_rom_addr", longint'(rom_addr), 0);
    rst = 1'b0;

    // Abort a 10x10 sprite part-way through RUN
    @(negedge clk);
    cur_x = 0; cur_y = 0; cur_w = 10; cur_base = 300;
    clear_stats();
    bus.req_valid = 1'b1;
    bus.req_id    = 6'd25;
    bus.req_x     = 11'd0;
    bus.req_y     = 11'd0;
    k = 0;
    while (!bus.req_ready && k < 100) begin @(negedge clk); k++; end
    t = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_pre_busy", longint'(busy), 1);
    chk("abort_pre_writes", n_wr, 18);
    rst = 1'b1;
    @(posedge clk);
    #1;
    clear_stats();
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_writes", n_wr, 0);
    chk("abort_done",   n_done, 0);
    chk("abort_ready",  longint'(bus.req_ready), 1);
    chk("abort_obj_id", longint'(obj_id), 0);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Two requests with valid held high throughout
    @(negedge clk);
    clear_stats();
    bus.req_valid = 1'b1;
    bus.req_id    = 6'd63;
    bus.req_x     = 11'd10;
    bus.req_y     = 11'd10;
    k = 0;
    while (!bus.req_ready && k < 100) begin @(negedge clk); k++; end
    t = cyc;
    for (int j = 1; j < 15; j++) begin
      @(negedge clk);
      if (j == 1) begin
        bus.req_id = 6'd1;
        bus.req_x  = 11'd20;
        bus.req_y  = 11'd20;
      end
      rec_ready[j] = bus.req_ready;
      rec_done[j]  = done;
      rec_obj[j]   = obj_id;
      if (j == 5) bus.req_valid = 1'b0;
    end
    chk("b2b_cycles",    cyc - t, 14);
    chk("b2b_obj_hold",  rec_obj[2], 63);
    chk("b2b_ready_t3",  rec_ready[3], 0);
    chk("b2b_done_t3",   rec_done[3], 1);
    chk("b2b_ready_t4",  rec_ready[4], 1);
    chk("b2b_obj_t4",    rec_obj[4], 63);
    chk("b2b_obj_t5",    rec_obj[5], 1);
    chk("b2b_done_t12",  rec_done[12], 1);
    chk("b2b_ready_t13", rec_ready[13], 1);
    chk("b2b_writes",    n_wr, tr ? 4 : 7);
    chk("b2b_done_cnt",  n_done, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
